// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered line decoder with 74x138 enables and auto-scan mode
// Optional blanking between scan lines when DECODER_SCAN_BLANK_EN is defined.
module decoder_scan #(
    parameter int SEL_W = 3,
    parameter int OUT_N = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g1,
    input  logic             g2a,
    input  logic             g2b,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_N-1:0] Y,
    output logic [SEL_W-1:0] idx,
    output logic             wrap,
    output logic             err
);

    localparam logic [SEL_W:0]   LINES = OUT_N[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUT_N - 1);

    function automatic logic [OUT_N-1:0] line_low(input logic [SEL_W-1:0] i);
        return ~({{(OUT_N-1){1'b0}}, 1'b1} << i);
    endfunction

    logic             en, tick;
    logic [SEL_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             mode_q;
    logic [OUT_N-1:0] y_d;
    logic [SEL_W-1:0] idx_d;
    logic             wrap_d, err_d;
`ifdef DECODER_SCAN_BLANK_EN
    logic             blank_q, blank_d;
`endif

    always_comb begin
        en      = g1 & ~g2a & ~g2b;
        tick    = (pre_q == div);
        cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        y_d     = '1;
        idx_d   = idx;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
`ifdef DECODER_SCAN_BLANK_EN
        blank_d = blank_q;
`endif
        if (!en) begin
            // Disabled: lines blank, scan position frozen.
        end else if (!mode) begin
`ifdef DECODER_SCAN_BLANK_EN
            blank_d = 1'b0;
`endif
            if ({1'b0, sel} < LINES) begin
                y_d   = line_low(sel);
                idx_d = sel;
            end else begin
                err_d = 1'b1;
            end
        end else if (!mode_q) begin
            // Scan entry restarts at line 0 without a wrap pulse.
            cnt_d = '0;
            pre_d = '0;
            y_d   = line_low('0);
            idx_d = '0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_d = 1'b0;
`endif
        end
`ifdef DECODER_SCAN_BLANK_EN
        else if (blank_q) begin
            // Prescaler pauses during the blank cycle so each line keeps div+1 lit cycles.
            blank_d = 1'b0;
            y_d     = line_low(cnt_q);
            idx_d   = cnt_q;
            wrap_d  = (cnt_q == '0);
        end else if (tick) begin
            pre_d   = '0;
            cnt_d   = cnt_nxt;
            idx_d   = cnt_nxt;
            blank_d = 1'b1;
        end
`else
        else if (tick) begin
            pre_d  = '0;
            cnt_d  = cnt_nxt;
            y_d    = line_low(cnt_nxt);
            idx_d  = cnt_nxt;
            wrap_d = (cnt_q == LAST);
        end
`endif
        else begin
            // Free-running increment: a prescaler above a lowered div rolls over naturally.
            pre_d = pre_q + 1'b1;
            y_d   = line_low(cnt_q);
            idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y      <= '1;
            idx    <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
            cnt_q  <= '0;
            pre_q  <= '0;
            mode_q <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= 1'b0;
`endif
        end else begin
            Y      <= y_d;
            idx    <= idx_d;
            wrap   <= wrap_d;
            err    <= err_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            mode_q <= mode;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - randomized bench for decoder_scan against a behavioural model
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       g1 = 1'b0, g2a = 1'b0, g2b = 1'b0, mode = 1'b0;
    logic [2:0] sel = '0;
    logic [3:0] div = '0;
    logic [7:0] y8;
    logic [5:0] y6;
    logic [2:0] idx8, idx6;
    logic       wrap8, wrap6, err8, err6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .OUT_N(8), .DIV_W(4)) dut8 (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b), .mode(mode),
        .sel(sel), .div(div), .Y(y8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    decoder_scan #(.SEL_W(3), .OUT_N(6), .DIV_W(4)) dut6 (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b), .mode(mode),
        .sel(sel), .div(div), .Y(y6), .idx(idx6), .wrap(wrap6), .err(err6)
    );

`ifdef DECODER_SCAN_BLANK_EN
    localparam int EXP_WRAPS = 1;
`else
    localparam int EXP_WRAPS = 2;
`endif

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: line position, elapsed cycles on the line, pending blank, per width.
    int  nn[2] = '{8, 6};
    int  mline[2], mph[2], mblank[2];
    int  ey[2], eidx[2], ewrap[2], eerr[2];
    int  pmode = 0;
    bit  en_was_low = 1'b1;
    bit  started = 1'b0;

    always begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int mask;
            int stepping;
            mask = (1 << nn[k]) - 1;
            if (rst) begin
                mline[k] = 0; mph[k] = 0; mblank[k] = 0;
                ey[k] = mask; eidx[k] = 0; ewrap[k] = 0; eerr[k] = 0;
            end else begin
                ewrap[k] = 0;
                eerr[k]  = 0;
                if (!(g1 && !g2a && !g2b)) begin
                    ey[k] = mask;
                end else if (!mode) begin
                    mblank[k] = 0;
                    if (int'(sel) < nn[k]) begin
                        ey[k] = mask & ~(1 << sel);
                        eidx[k] = sel;
                    end else begin
                        ey[k] = mask;
                        eerr[k] = 1;
                    end
                end else if (pmode == 0) begin
                    mline[k] = 0; mph[k] = 0; mblank[k] = 0;
                    ey[k] = mask & ~1; eidx[k] = 0;
                end else begin
`ifdef DECODER_SCAN_BLANK_EN
                    if (mblank[k] != 0) begin
                        mblank[k] = 0;
                        ey[k] = mask & ~(1 << mline[k]);
                        eidx[k] = mline[k];
                        ewrap[k] = (mline[k] == 0);
                    end else if (mph[k] == int'(div)) begin
                        mph[k] = 0;
                        mline[k] = (mline[k] + 1) % nn[k];
                        mblank[k] = 1;
                        ey[k] = mask;
                        eidx[k] = mline[k];
                    end else begin
                        mph[k] = (mph[k] + 1) % 16;
                        ey[k] = mask & ~(1 << mline[k]);
                        eidx[k] = mline[k];
                    end
`else
                    stepping = (mph[k] == int'(div)) ? 1 : 0;
                    mph[k] = stepping ? 0 : (mph[k] + 1) % 16;
                    if (stepping != 0) begin
                        ewrap[k] = (mline[k] == nn[k] - 1);
                        mline[k] = (mline[k] + stepping) % nn[k];
                    end
                    ey[k] = mask & ~(1 << mline[k]);
                    eidx[k] = mline[k];
`endif
                end
            end
        end
        en_was_low = !(g1 && !g2a && !g2b);
        pmode = rst ? 0 : int'(mode);
        started = 1'b1;
    end

    always begin
        @(negedge clk);
        if (started) begin
            check("y8", int'(y8), ey[0]);
            check("idx8", int'(idx8), eidx[0]);
            check("wrap8", int'(wrap8), ewrap[0]);
            check("err8", int'(err8), eerr[0]);
            check("y6", int'(y6), ey[1]);
            check("idx6", int'(idx6), eidx[1]);
            check("wrap6", int'(wrap6), ewrap[1]);
            check("err6", int'(err6), eerr[1]);
            check("y8_single_low", ($countones(~y8) <= 1) ? 1 : 0, 1);
            if (en_was_low) check("y8_blank_after_en0", int'(y8), 8'hFF);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        int seq[6];
        rst = 1'b1;
        step();
        step();
        check("reset_y8", int'(y8), 8'hFF);
        check("reset_idx8", int'(idx8), 0);
        check("reset_wrap_err", int'({wrap8, err8}), 0);

        rst = 1'b0; g1 = 1'b1; g2a = 1'b0; g2b = 1'b0; mode = 1'b0; sel = 3'd5;
        step();
        check("direct_sel5_y", int'(y8), 8'hDF);
        check("direct_sel5_idx", int'(idx8), 5);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
        end
        check("oob_err6", int'(err6), 1);
        check("oob_y6", int'(y6), 6'h3F);

        for (int c = 0; c < 40; c++) begin
            sel = 3'(c);
            g1  = (c != 10);
            g2a = (c == 22);
            g2b = (c == 37);
            step();
        end
        g1 = 1'b1; g2a = 1'b0; g2b = 1'b0;

        div = 4'd3; mode = 1'b0;
        step();
        mode = 1'b1;
        step();
        check("scan_entry_y", int'(y8), 8'hFE);
        wraps = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (wrap8) wraps++;
        end
        check("scan_wrap_count", wraps, EXP_WRAPS);

        for (int c = 0; c < 200 && idx8 != 3'd4; c++) step();
        check("reach_idx4", int'(idx8), 4);
        g2b = 1'b1;
        for (int c = 0; c < 7; c++) step();
        check("freeze_y", int'(y8), 8'hFF);
        check("freeze_idx", int'(idx8), 4);
        g2b = 1'b0;
        for (int c = 0; c < 20; c++) step();

        div = 4'd0;
        for (int c = 0; c < 40 && idx8 != 3'd6; c++) step();
        check("reach_idx6", int'(idx8), 6);
        rst = 1'b1;
        step();
        check("midscan_rst_y", int'(y8), 8'hFF);
        check("midscan_rst_idx", int'(idx8), 0);
        check("midscan_rst_wrap", int'(wrap8), 0);
        rst = 1'b0;
        step();
        check("rescan_y", int'(y8), 8'hFE);
        check("rescan_idx", int'(idx8), 0);

`ifdef DECODER_SCAN_BLANK_EN
        div = 4'd1; mode = 1'b0;
        step();
        mode = 1'b1;
        seq = '{8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFF};
        for (int c = 0; c < 6; c++) begin
            step();
            check("blank_seq", int'(y8), seq[c]);
        end
`endif

        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            g1   = ($urandom_range(0, 9) != 0);
            g2a  = ($urandom_range(0, 11) == 0);
            g2b  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) div = 4'($urandom_range(0, 5));
            step();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
